// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller states, access size encodings, byte-strobe table and
// store-data lane placement.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] SZ_BYTE = 3'd0;
    localparam logic [2:0] SZ_HALF = 3'd1;
    localparam logic [2:0] SZ_WORD = 3'd2;

    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    // Byte enables for an access of size sz at byte offset off; sizes 3..7 act as word.
    function automatic logic [3:0] strobe_for(input logic [2:0] sz, input logic [1:0] off);
        logic [3:0] base;
        case (sz)
            SZ_BYTE: base = STRB_BYTE;
            SZ_HALF: base = STRB_HALF;
            default: base = STRB_WORD;
        endcase
        return base << off;
    endfunction

    // Right-aligned store data masked to its size and moved to its byte lane.
    function automatic logic [31:0] lane_data(input logic [2:0] sz, input logic [1:0] off,
                                              input logic [31:0] data);
        logic [31:0] masked;
        case (sz)
            SZ_BYTE: masked = {24'h0, data[7:0]};
            SZ_HALF: masked = {16'h0, data[15:0]};
            default: masked = data;
        endcase
        return masked << {off, 3'b000};
    endfunction

endpackage

// File: rtl/dcache_if.sv
// Core-side load/store port and next-level memory port of the data cache.
// slave: the cache; master: the core/memory environment driving it.
interface dcache_if;
    logic        re;
    logic [31:0] raddr;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [2:0]  access_sz;
    logic [31:0] rdata;
    logic        hit;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  re, raddr, we, waddr, wdata, access_sz, mem_rdata, mem_ack,
        output rdata, hit, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output re, raddr, we, waddr, wdata, access_sz, mem_rdata, mem_ack,
        input  rdata, hit, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_ram.sv
// Data array: one registered read port, one write port with byte enables.
// Each byte lane is its own array so byte-enable writes infer cleanly.
module dcache_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_be,
    input  logic [31:0]   wr_data
);
    localparam int DEPTH = 1 << AW;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] lane_q_reg;

        // Byte-lane write plus registered read.
        always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
                mem[wr_addr] <= wr_data[8*gi +: 8];
            end
            lane_q_reg <= mem[rd_addr];
        end

        assign rd_data[8*gi +: 8] = lane_q_reg;
    end
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Loads hit in one cycle; misses refill a whole line word by word.
// Optional read hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef DCACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    dcache_if.slave     bus
);
    localparam int WB     = $clog2(LINE_WORDS);
    localparam int IB     = $clog2(LINES);
    localparam int TAG_LO = 2 + WB + IB;
    localparam int TAG_W  = 32 - TAG_LO;
    localparam int RAM_AW = IB + WB;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

    state_t            state_reg, state_next;
    logic [WB-1:0]     cnt_reg, cnt_next;
    logic [31:0]       req_addr_reg, req_addr_next;
    logic              hit_reg, hit_next;
    logic              rsrc_reg, rsrc_next;     // 1: rdata comes from the RAM read port
    logic [31:0]       word_reg, word_next;     // requested word captured during refill
    logic              mem_rd_req_reg, mem_rd_req_next;
    logic              mem_wr_req_reg, mem_wr_req_next;
    logic [31:0]       mem_addr_reg, mem_addr_next;
    logic [31:0]       mem_wdata_reg, mem_wdata_next;
    logic [3:0]        mem_wstrb_reg, mem_wstrb_next;
    logic [LINES-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_reg [LINES];
    logic              line_fill;

    logic [IB-1:0]     r_idx, w_idx, q_idx;
    logic [TAG_W-1:0]  r_tag, w_tag, q_tag;
    logic [WB-1:0]     q_word;
    logic              r_hit, w_hit;

    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [3:0]        ram_wbe;
    logic [31:0]       ram_wdata, ram_q;
    logic              unused_addr_bits;

    assign r_idx  = bus.raddr[2+WB +: IB];
    assign r_tag  = bus.raddr[31:TAG_LO];
    assign w_idx  = bus.waddr[2+WB +: IB];
    assign w_tag  = bus.waddr[31:TAG_LO];
    assign q_idx  = req_addr_reg[2+WB +: IB];
    assign q_tag  = req_addr_reg[31:TAG_LO];
    assign q_word = req_addr_reg[2 +: WB];
    assign r_hit  = valid_reg[r_idx] && (tag_reg[r_idx] == r_tag);
    assign w_hit  = valid_reg[w_idx] && (tag_reg[w_idx] == w_tag);
    assign unused_addr_bits = ^{bus.raddr[1:0], req_addr_reg[1:0]};

    dcache_ram #(.AW(RAM_AW)) u_ram (
        .clk     (clk),
        .rd_addr (bus.raddr[2 +: RAM_AW]),
        .rd_data (ram_q),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_be   (ram_wbe),
        .wr_data (ram_wdata)
    );

    // Next-state, next-output and data-array write selection.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        req_addr_next   = req_addr_reg;
        hit_next        = 1'b1;
        rsrc_next       = 1'b0;
        word_next       = word_reg;
        mem_rd_req_next = mem_rd_req_reg;
        mem_wr_req_next = mem_wr_req_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_wstrb_next  = mem_wstrb_reg;
        line_fill       = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = bus.waddr[2 +: RAM_AW];
        ram_wbe         = strobe_for(bus.access_sz, bus.waddr[1:0]);
        ram_wdata       = lane_data(bus.access_sz, bus.waddr[1:0], bus.wdata);
        case (state_reg)
            IDLE: begin
                if (bus.we) begin
                    // Store wins over a simultaneous load; cached copy merged now.
                    state_next      = WRITE;
                    hit_next        = 1'b0;
                    mem_wr_req_next = 1'b1;
                    mem_addr_next   = {bus.waddr[31:2], 2'b00};
                    mem_wdata_next  = ram_wdata;
                    mem_wstrb_next  = ram_wbe;
                    ram_we          = w_hit;
                end else if (bus.re && !r_hit) begin
                    state_next      = REFILL;
                    hit_next        = 1'b0;
                    req_addr_next   = bus.raddr;
                    cnt_next        = '0;
                    mem_rd_req_next = 1'b1;
                    mem_addr_next   = {bus.raddr[31:2+WB], {WB{1'b0}}, 2'b00};
                end else if (bus.re) begin
                    rsrc_next = 1'b1;
                end
            end
            REFILL: begin
                hit_next = 1'b0;
                if (bus.mem_ack) begin
                    ram_we    = 1'b1;
                    ram_waddr = {q_idx, cnt_reg};
                    ram_wbe   = 4'hF;
                    ram_wdata = bus.mem_rdata;
                    cnt_next  = cnt_reg + 1'b1;
                    if (cnt_reg == q_word) begin
                        word_next = bus.mem_rdata;
                    end
                    if (cnt_reg == LAST_WORD) begin
                        state_next      = RESP;
                        hit_next        = 1'b1;
                        mem_rd_req_next = 1'b0;
                        line_fill       = 1'b1;
                    end else begin
                        mem_addr_next = {req_addr_reg[31:2+WB], cnt_next, 2'b00};
                    end
                end
            end
            WRITE: begin
                hit_next = 1'b0;
                if (bus.mem_ack) begin
                    state_next      = RESP;
                    hit_next        = 1'b1;
                    mem_wr_req_next = 1'b0;
                    mem_wstrb_next  = 4'h0;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control and memory-port registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            req_addr_reg   <= '0;
            hit_reg        <= 1'b1;
            rsrc_reg       <= 1'b0;
            word_reg       <= '0;
            mem_rd_req_reg <= 1'b0;
            mem_wr_req_reg <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wstrb_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            req_addr_reg   <= req_addr_next;
            hit_reg        <= hit_next;
            rsrc_reg       <= rsrc_next;
            word_reg       <= word_next;
            mem_rd_req_reg <= mem_rd_req_next;
            mem_wr_req_reg <= mem_wr_req_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_wstrb_reg  <= mem_wstrb_next;
        end
    end

    // Valid bits: a line becomes valid only once its last refill beat lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
        end else if (line_fill) begin
            valid_reg[q_idx] <= 1'b1;
        end
    end

    // Tags need no reset; the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (line_fill) begin
            tag_reg[q_idx] <= q_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    // Saturating read hit/miss counters, sampled with the load request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state_reg == IDLE && bus.re && !bus.we) begin
            if (r_hit && stat_hits != 32'hFFFF_FFFF) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (!r_hit && stat_misses != 32'hFFFF_FFFF) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

    assign bus.hit        = hit_reg;
    assign bus.rdata      = rsrc_reg ? ram_q : word_reg;
    assign bus.mem_rd_req = mem_rd_req_reg;
    assign bus.mem_wr_req = mem_wr_req_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_wstrb  = mem_wstrb_reg;
endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios followed by random
// loads/stores, compared against a memory image plus a record of which
// line address each cache slot holds.
module tb_dcache;
    localparam int LINES      = 64;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dcache_if bus ();
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
    int          exp_hits = 0;
    int          exp_misses = 0;
`endif

    dcache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef DCACHE_STATS_EN
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Reference state: backing memory words and the line address per cache slot.
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] slot_line [LINES];
    logic        slot_ok [LINES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_m.exists(wa)) return mem_m[wa];
        return (wa * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic int slot_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < LINES; i++) slot_ok[i] = 1'b0;
    endtask

    // Load; abort_after > 0 pulses reset once that many refill beats were acked.
    task automatic load(input logic [31:0] a, input logic [2:0] sz, input int abort_after);
        logic        exp_hit, done;
        logic [31:0] exp_word, base;
        int          n;
        exp_hit  = slot_ok[slot_of(a)] && (slot_line[slot_of(a)] == line_of(a));
        exp_word = mem_word(a);
        base     = line_of(a);
`ifdef DCACHE_STATS_EN
        if (exp_hit) exp_hits++; else exp_misses++;
`endif
        @(negedge clk);
        bus.re = 1'b1; bus.raddr = a; bus.access_sz = sz;
        @(negedge clk);
        check("ld_hit", bus.hit, exp_hit);
        if (exp_hit) begin
            check("ld_data", bus.rdata, exp_word);
            check("ld_no_rd", bus.mem_rd_req, 1'b0);
            bus.re = 1'b0;
            $display("load  %h hit  data=%h", a, bus.rdata);
            return;
        end
        n = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            bus.mem_ack = 1'b0;
            if (abort_after > 0 && n == abort_after) begin
                rst_n = 1'b0; bus.re = 1'b0;
                #1;
                check("rst_hit", bus.hit, 1'b1);
                check("rst_rdata", bus.rdata, 32'h0);
                check("rst_rd_req", bus.mem_rd_req, 1'b0);
                check("rst_wr_req", bus.mem_wr_req, 1'b0);
                check("rst_addr", bus.mem_addr, 32'h0);
                check("rst_wdata", bus.mem_wdata, 32'h0);
                check("rst_wstrb", bus.mem_wstrb, 4'h0);
                @(negedge clk);
                rst_n = 1'b1;
                clear_model();
`ifdef DCACHE_STATS_EN
                exp_hits = 0; exp_misses = 0;
`endif
                $display("load  %h aborted by reset after %0d beats", a, n);
                return;
            end
            if (bus.hit) begin
                done = 1'b1;
                break;
            end
            check("rf_rd_req", bus.mem_rd_req, 1'b1);
            check("rf_no_wr", bus.mem_wr_req, 1'b0);
            check("rf_addr", bus.mem_addr, base + 32'(4 * n));
            bus.mem_rdata = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                bus.mem_rdata = mem_word(base + 32'(4 * n));
                bus.mem_ack = 1'b1;
                n++;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        bus.re = 1'b0;
        check("rf_done", done, 1'b1);
        check("rf_beats", n, LINE_WORDS);
        check("rf_data", bus.rdata, exp_word);
        slot_ok[slot_of(a)] = 1'b1;
        slot_line[slot_of(a)] = base;
        $display("load  %h miss data=%h beats=%0d", a, bus.rdata, n);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        logic [3:0]  exp_strb;
        logic [31:0] exp_data, w;
        logic        done, saw_rd;
        int          acks;
        case (sz)
            3'd0:    begin exp_strb = 4'b0001; exp_data = d & 32'h0000_00FF; end
            3'd1:    begin exp_strb = 4'b0011; exp_data = d & 32'h0000_FFFF; end
            default: begin exp_strb = 4'b1111; exp_data = d; end
        endcase
        exp_strb = exp_strb << a[1:0];
        exp_data = exp_data << (8 * a[1:0]);
        @(negedge clk);
        bus.we = 1'b1; bus.waddr = a; bus.wdata = d; bus.access_sz = sz;
        @(negedge clk);
        check("st_hit", bus.hit, 1'b0);
        check("st_wr_req", bus.mem_wr_req, 1'b1);
        check("st_no_rd", bus.mem_rd_req, 1'b0);
        check("st_addr", bus.mem_addr, {a[31:2], 2'b00});
        check("st_wstrb", bus.mem_wstrb, exp_strb);
        check("st_wdata", bus.mem_wdata, exp_data);
        acks = 0; done = 1'b0; saw_rd = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            bus.mem_ack = 1'b0;
            if (bus.hit) begin
                done = 1'b1;
                break;
            end
            if (bus.mem_rd_req) saw_rd = 1'b1;
            if (bus.mem_wr_req && $urandom_range(0, 2) != 0) begin
                bus.mem_ack = 1'b1;
                acks++;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        bus.we = 1'b0;
        check("st_done", done, 1'b1);
        check("st_acks", acks, 1);
        check("st_no_refill", saw_rd, 1'b0);
        w = mem_word(a);
        for (int i = 0; i < 4; i++) if (exp_strb[i]) w[8*i +: 8] = exp_data[8*i +: 8];
        mem_m[{a[31:2], 2'b00}] = w;
        $display("store %h data=%h strb=%b", a, exp_data, exp_strb);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        bus.re = 1'b0; bus.raddr = '0; bus.we = 1'b0; bus.waddr = '0;
        bus.wdata = '0; bus.access_sz = 3'd2; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        check("rst_hit", bus.hit, 1'b1);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_rd_req", bus.mem_rd_req, 1'b0);
        check("rst_wr_req", bus.mem_wr_req, 1'b0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wstrb", bus.mem_wstrb, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hit", bus.hit, 1'b1);

        load(32'h100, 3'd2, 0);
        load(32'h104, 3'd2, 0);
        store(32'h106, 32'h0000_00AB, 3'd0);
        load(32'h104, 3'd0, 0);
        check("byte2_ab", {24'h0, bus.rdata[23:16]}, 32'hAB);
        store(32'h2000, $urandom, 3'd2);
        load(32'h2000, 3'd2, 0);
`ifdef DCACHE_STATS_EN
        check("stat_hits", stat_hits, exp_hits);
        check("stat_misses", stat_misses, exp_misses);
`endif
        load(32'h3000, 3'd2, 2);
        load(32'h100, 3'd2, 0);
        load(32'h3000, 3'd2, 0);

        for (int i = 0; i < 120; i++) begin
            a  = $urandom_range(0, 4095);
            sz = 3'($urandom_range(0, 7));
            if (sz == 3'd1) a[0] = 1'b0;
            else if (sz != 3'd0) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) < 4) store(a, $urandom, sz);
            else load(a, sz, 0);
        end
`ifdef DCACHE_STATS_EN
        check("stat_hits_end", stat_hits, exp_hits);
        check("stat_misses_end", stat_misses, exp_misses);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter LINES, default 64, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (fixed power of two).
REQ-003 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have re, input, 1, core load request.
REQ-006 SHALL have raddr, input, 32, load byte address.
REQ-007 SHALL have we, input, 1, core store request.
REQ-008 SHALL have waddr, input, 32, store byte address.
REQ-009 SHALL have wdata, input, 32, store data, right-aligned (LSB-justified).
REQ-010 SHALL have access_sz, input, 3, access size: 0 byte, 1 half, 2 word.
REQ-011 SHALL have rdata, output, 32, aligned word containing the addressed data; the core shifts it by the address low bits.
REQ-012 SHALL have hit, output, 1, high means the previous request completed and rdata is valid.
REQ-013 SHALL have mem_rd_req, mem_wr_req, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0], all outputs, next-level memory request.
REQ-014 SHALL have mem_rdata[31:0] and mem_ack, inputs; mem_ack completes one single-word transfer.

Function
REQ-015 SHALL sample a request only in IDLE; if we and re are both high, we wins and re is ignored.
REQ-016 SHALL treat access_sz values 3..7 as word.
REQ-017 SHALL use FSM states IDLE, REFILL, WRITE, RESP.
REQ-018 SHALL, on a read hit sampled at edge T, drive hit=1 and the word in the cycle after T, remaining in IDLE (one-cycle latency).
REQ-019 SHALL, on a read miss, drive hit=0 from the cycle after T and enter REFILL.
REQ-020 SHALL, in REFILL, issue LINE_WORDS mem reads starting at word 0 of the line; a 2-bit counter advances on each mem_ack and wraps after LINE_WORDS-1.
REQ-021 SHALL hold mem_rd_req high and mem_addr stable until mem_ack.
REQ-022 SHALL, after the last refill ack, write the tag, set valid, and enter RESP; RESP drives hit=1 and the requested word for one cycle, then returns to IDLE.
REQ-023 SHALL treat stores as write-through, no-write-allocate.
REQ-024 SHALL, on a store, enter WRITE with hit=0 and issue one mem write; mem_wdata is wdata shifted to byte lane waddr[1:0]; mem_wstrb is 0001/0011/1111 shifted by waddr[1:0].
REQ-025 SHALL, on a store hit, merge the enabled lanes into the cached word in the same cycle the store is sampled.
REQ-026 SHALL, in WRITE, go to RESP on mem_ack; a store never allocates a line.
REQ-027 SHALL ignore re and we while not in IDLE; the core holds the request stable while hit=0.
REQ-028 SHALL never assert mem_rd_req and mem_wr_req together.
REQ-029 SHALL drive hit=1 when idle with no outstanding request.

Reset
REQ-030 SHALL, while rst_n=0: clear all valid bits, set the FSM to IDLE and the refill counter to 0, and drive hit=1, rdata=0, mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-031 SHALL abandon any refill or write in flight when reset asserts; a partially refilled line stays invalid.

Configuration
REQ-032 SHALL, when DCACHE_STATS_EN is defined, add 32-bit outputs stat_hits and stat_misses; these count read hits and read misses, reset to 0, and saturate at 0xFFFFFFFF.
REQ-033 SHALL, without DCACHE_STATS_EN, have no such ports and no counter logic.

Structure
REQ-034 SHALL take the FSM state enum, access_sz encodings and strobe table from shared package dcache_pkg.
REQ-035 SHALL instantiate sub-module dcache_ram as the data array: one read port, one write port with 4-bit byte enables, and registered read.
REQ-036 SHALL hold tags and valid bits as flops inside dcache.

Verification
REQ-037 SHALL cover: after reset, load of 0x100 (miss) -> 4 mem reads at 0x100, 0x104, 0x108, 0x10C; then hit=1 with the word from 0x100.
REQ-038 SHALL cover: repeat load of 0x104 -> hit=1 the next cycle with no mem request.
REQ-039 SHALL cover: byte store 0xAB to 0x106 (hit) -> mem_wstrb=0100 and mem_wdata=0x00AB0000; a later load of 0x104 returns byte 2 = 0xAB.
REQ-040 SHALL cover: store to uncached 0x2000 -> one mem write and no refill; a following load of 0x2000 misses.
REQ-041 SHALL cover: rst_n pulsed low after the second refill ack -> outputs return to reset values, and a reload of 0x100 refills again.
REQ-042 SHALL cover: with DCACHE_STATS_EN, the first four scenarios end with stat_hits=2 and stat_misses=2.
